// File: rtl/vc_test_mem_pkg.sv
// Shared definitions for the multi-port test memory: message type encodings,
// the port-count ceiling and the round-robin successor helper.
package vc_test_mem_pkg;

    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ       = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE_INIT = 3'd2;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_AMO_ADD    = 3'd3;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_AMO_AND    = 3'd4;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_AMO_OR     = 3'd5;

    localparam int VC_MEM_MAX_PORTS = 16;

    // Next index after idx in a ring of n entries (n in 1..16).
    function automatic logic [3:0] rr_next(input logic [3:0] idx, input logic [4:0] n);
        if ({1'b0, idx} >= n - 5'd1)
            return 4'd0;
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/vc_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr, scanning upward with wrap.
module vc_rr_pick #(
    parameter int p_n     = 4,
    parameter int p_ptr_w = 2
) (
    input  logic [p_n-1:0]     req,
    input  logic [p_ptr_w-1:0] ptr,
    output logic [p_n-1:0]     grant
);

    localparam int IW = (p_n > 1) ? $clog2(p_n) : 1;

    logic          found;
    logic [IW-1:0] idx;
    int            sum;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < p_n; k++) begin
            sum = int'(ptr) + k;
            if (sum >= p_n)
                sum = sum - p_n;
            idx = IW'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_test_mem_amo_scheduler.sv
// Arbitrates the single AMO slot of the test memory among its ports, with
// starvation watchdogs, a fire counter and a sticky protocol-error flag.
module vc_test_mem_amo_scheduler
    import vc_test_mem_pkg::*;
#(
    parameter int p_num_ports    = 4,
    parameter int p_wait_sz      = 8,
    parameter int p_starve_limit = 64,
    parameter int p_cnt_sz       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_num_ports-1:0] amo_req,
    input  logic [p_num_ports-1:0] amo_fire,
    output logic [p_num_ports-1:0] amo_grant,
    output logic [p_num_ports-1:0] starve,
    output logic [p_cnt_sz-1:0]    amo_fire_count,
    output logic                   protocol_err
);

    localparam int PTR_W = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
    localparam logic [p_wait_sz-1:0] STARVE_LIM = p_wait_sz'(p_starve_limit);

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       ptr_next;
    logic [p_wait_sz-1:0]   wait_cnt  [p_num_ports];
    logic [p_wait_sz-1:0]   wait_next [p_num_ports];
    logic [p_cnt_sz-1:0]    fire_cnt;
    logic                   err;
    logic [p_num_ports-1:0] pick_grant;
    logic                   fire_any;
    logic                   err_now;

    vc_rr_pick #(
        .p_n     (p_num_ports),
        .p_ptr_w (PTR_W)
    ) u_pick (
        .req   (amo_req),
        .ptr   (rr_ptr),
        .grant (pick_grant)
    );

    assign amo_grant      = reset ? '0 : pick_grant;
    assign fire_any       = |amo_fire;
    assign amo_fire_count = fire_cnt;
    assign protocol_err   = err;

    assign err_now = ((amo_fire & (amo_fire - p_num_ports'(1))) != '0)
                  || ((amo_fire & ~amo_grant) != '0)
                  || ((amo_fire & ~amo_req) != '0);

    // Descending scan so the lowest-index firing port decides the pointer.
    always_comb begin
        ptr_next = rr_ptr;
        for (int i = p_num_ports - 1; i >= 0; i--) begin
            if (amo_fire[i])
                ptr_next = PTR_W'(rr_next(4'(i), 5'(p_num_ports)));
        end
    end

    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            wait_next[i] = wait_cnt[i];
            if (!amo_req[i] || amo_fire[i])
                wait_next[i] = '0;
            else if (wait_cnt[i] != '1)
                wait_next[i] = wait_cnt[i] + p_wait_sz'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            fire_cnt <= '0;
            err      <= 1'b0;
            starve   <= '0;
            for (int i = 0; i < p_num_ports; i++)
                wait_cnt[i] <= '0;
        end else begin
            rr_ptr <= ptr_next;
            if (fire_any)
                fire_cnt <= fire_cnt + p_cnt_sz'(1);
            if (err_now)
                err <= 1'b1;
            for (int i = 0; i < p_num_ports; i++) begin
                wait_cnt[i] <= wait_next[i];
                starve[i]   <= (wait_next[i] >= STARVE_LIM);
            end
        end
    end

endmodule

// File: tb/tb_vc_test_mem_amo_scheduler.sv
// Self-checking bench for the AMO scheduler: expected values are queued as
// stimulus is driven and popped when the matching DUT output is sampled.
module tb_vc_test_mem_amo_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  amo_req;
    logic [3:0]  amo_fire;
    logic [3:0]  amo_grant;
    logic [3:0]  starve;
    logic [31:0] amo_fire_count;
    logic        protocol_err;

    logic [3:0]  req4;
    logic [3:0]  fire4;
    logic [3:0]  grant4;
    logic [3:0]  starve4;
    logic [3:0]  count4;
    logic        err4;

    int          n_checks;
    int          n_fail;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp;

    vc_test_mem_amo_scheduler #(
        .p_num_ports    (4),
        .p_wait_sz      (8),
        .p_starve_limit (4),
        .p_cnt_sz       (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .amo_req        (amo_req),
        .amo_fire       (amo_fire),
        .amo_grant      (amo_grant),
        .starve         (starve),
        .amo_fire_count (amo_fire_count),
        .protocol_err   (protocol_err)
    );

    vc_test_mem_amo_scheduler #(
        .p_num_ports    (4),
        .p_wait_sz      (8),
        .p_starve_limit (4),
        .p_cnt_sz       (4)
    ) dut4 (
        .clk            (clk),
        .reset          (reset),
        .amo_req        (req4),
        .amo_fire       (fire4),
        .amo_grant      (grant4),
        .starve         (starve4),
        .amo_fire_count (count4),
        .protocol_err   (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation ran past its time budget");
        $fatal(1, "[TB] timeout");
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; amo_req = 4'b0000; amo_fire = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; amo_req = 4'b1111; amo_fire = 4'b0000;
        req4 = 4'b0000; fire4 = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (amo_grant !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_grant: got %b expected %b", amo_grant, 4'b0000);
        end
        n_checks++;
        if (amo_fire_count !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", amo_fire_count);
        end
        n_checks++;
        if (protocol_err !== 1'b0 || starve !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_flags: got err=%b starve=%b expected 0/0000", protocol_err, starve);
        end
        n_checks++;
        if (count4 !== 4'd0) begin
            n_fail++; $display("[TB] FAIL reset_count4: got %0d expected 0", count4);
        end
        reset = 1'b0; amo_req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) exp_q.push_back(rr_exp[k]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            amo_req = 4'b1111; amo_fire = 4'b0000;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (amo_grant !== exp) begin
                n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, amo_grant, exp);
            end
            amo_fire = exp;
        end
        @(negedge clk);
        amo_req = 4'b0000; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_fire_count !== 32'd5) begin
            n_fail++; $display("[TB] FAIL rr_count: got %0d expected 5", amo_fire_count);
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rr_err: got %b expected 0", protocol_err);
        end
    endtask

    task automatic test_hold_grant();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            amo_req = 4'b0100; amo_fire = 4'b0000;
            #1;
            n_checks++;
            if (amo_grant !== 4'b0100) begin
                n_fail++; $display("[TB] FAIL hold_grant[%0d]: got %b expected 0100", c, amo_grant);
            end
            n_checks++;
            if (starve !== 4'b0000) begin
                n_fail++; $display("[TB] FAIL hold_starve[%0d]: got %b expected 0000", c, starve);
            end
            if (c == 3) amo_fire = 4'b0100;
        end
        @(negedge clk);
        amo_req = 4'b1111; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_grant !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL hold_ptr: got %b expected 1000", amo_grant);
        end
        n_checks++;
        if (amo_fire_count !== 32'd6) begin
            n_fail++; $display("[TB] FAIL hold_count: got %0d expected 6", amo_fire_count);
        end
        amo_req = 4'b0000;
    endtask

    task automatic test_starve();
        pulse_reset();
        for (int k = 0; k <= 6; k++) exp_q.push_back((k >= 4) ? 4'b1000 : 4'b0000);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            amo_req = (k < 6) ? 4'b1010 : 4'b0000; amo_fire = 4'b0000;
            #1;
            if (k < 6) begin
                n_checks++;
                if (amo_grant !== 4'b0010) begin
                    n_fail++; $display("[TB] FAIL starve_grant[%0d]: got %b expected 0010", k, amo_grant);
                end
            end
            exp = exp_q.pop_front();
            // Port 1 also waits while withheld, so only ports 3, 2 and 0 are compared here.
            n_checks++;
            if ((starve & 4'b1101) !== exp) begin
                n_fail++; $display("[TB] FAIL starve_flag[%0d]: got %b expected %b (bit1 ignored)", k, starve, exp);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (starve !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL starve_clear: got %b expected 0000", starve);
        end
    endtask

    task automatic test_protocol_err();
        @(negedge clk);
        amo_req = 4'b0010; amo_fire = 4'b0001;
        #1;
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL err_early: got %b expected 0", protocol_err);
        end
        @(negedge clk);
        amo_req = 4'b0000; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_fire_count !== 32'd1) begin
            n_fail++; $display("[TB] FAIL err_count: got %0d expected 1", amo_fire_count);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (protocol_err !== 1'b1) begin
                n_fail++; $display("[TB] FAIL err_sticky[%0d]: got %b expected 1", k, protocol_err);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_multi_hot();
        pulse_reset();
        @(negedge clk);
        amo_req = 4'b0011; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_grant !== 4'b0001 || protocol_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mh_pre: got grant=%b err=%b expected 0001/0", amo_grant, protocol_err);
        end
        amo_fire = 4'b0011;
        @(negedge clk);
        amo_req = 4'b1111; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_grant !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL mh_ptr: got %b expected 0010", amo_grant);
        end
        n_checks++;
        if (protocol_err !== 1'b1 || amo_fire_count !== 32'd1) begin
            n_fail++; $display("[TB] FAIL mh_err_count: got err=%b count=%0d expected 1/1", protocol_err, amo_fire_count);
        end
        amo_req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        @(negedge clk);
        amo_req = 4'b0010; amo_fire = 4'b0000;
        #1;
        amo_fire = 4'b0010;
        @(negedge clk);
        amo_req = 4'b1111; amo_fire = 4'b0000;
        #1;
        n_checks++;
        if (amo_grant !== 4'b0100) begin
            n_fail++; $display("[TB] FAIL mid_ptr2: got %b expected 0100", amo_grant);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (amo_grant !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL mid_grant_in_reset: got %b expected 0000", amo_grant);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (amo_grant !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL mid_grant_after: got %b expected 0001", amo_grant);
        end
        n_checks++;
        if (amo_fire_count !== 32'd0 || protocol_err !== 1'b0 || starve !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL mid_state: got count=%0d err=%b starve=%b expected 0/0/0000",
                               amo_fire_count, protocol_err, starve);
        end
        amo_req = 4'b0000;
    endtask

    task automatic test_count_wrap();
        for (int k = 0; k <= 16; k++) exp_q.push_back(4'(k));
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            req4  = (k < 16) ? 4'b0001 : 4'b0000;
            fire4 = 4'b0000;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (count4 !== exp) begin
                n_fail++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", k, count4, exp);
            end
            if (k < 16) fire4 = 4'b0001;
        end
        n_checks++;
        if (err4 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wrap_err: got %b expected 0", err4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_hold_grant();
        test_starve();
        test_protocol_err();
        test_multi_hot();
        test_reset_mid();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_test_mem_amo_scheduler.md
Name: vc_test_mem_amo_scheduler

Overview:
- Shares the single atomic read-modify-write slot of the multi-port test memory among p_num_ports request/response ports.
- Each port raises amo_req when an AMO request sits at its input. The scheduler returns a one-hot combinational amo_grant. Each port then reports amo_fire when its AMO actually enters the M stage.
- Round-robin fairness, a per-port starvation watchdog, a fire counter and a sticky protocol-error flag give the test harness visibility into contention.

Parameters:
- p_num_ports, 4, number of memory ports (1..16).
- p_wait_sz, 8, width of each per-port wait counter.
- p_starve_limit, 64, wait-cycle count at which a port's starve flag asserts; must be < 2^p_wait_sz.
- p_cnt_sz, 32, width of the AMO fire counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- amo_req  input  p_num_ports  per-port AMO pending; equals that port's arb_amo_en.
- amo_fire  input  p_num_ports  per-port AMO accepted this cycle (memreq_val && memreq_rdy && arb_amo_en).
- amo_grant  output  p_num_ports  one-hot or zero grant, combinational from amo_req and the pointer.
- starve  output  p_num_ports  registered; port waited >= p_starve_limit cycles.
- amo_fire_count  output  p_cnt_sz  registered total of accepted AMOs.
- protocol_err  output  1  registered, sticky error flag.

Behaviour:
- State: rr_ptr [$clog2(p_num_ports)-1:0], wait_cnt[p_num_ports][p_wait_sz], fire_cnt, err.
  - Reset (clk edge with reset=1): all cleared to 0.
  - amo_grant is forced to 0 while reset=1.
- Grant selection, zero latency:
  - Scan ports rr_ptr, rr_ptr+1, ... mod p_num_ports.
  - Grant the first port with amo_req=1.
  - If no request, amo_grant=0.
  - At most one bit of amo_grant is set.
- Pointer update:
  - On an edge where amo_fire[i]=1, rr_ptr <= (i+1) mod p_num_ports. Wrap from p_num_ports-1 goes to 0.
  - A grant that does not fire (the port's response queue is full) leaves rr_ptr unchanged, so the same port keeps the grant next cycle.
- Wait counters, for each port i at each edge:
  - If amo_req[i]=0 or amo_fire[i]=1: wait_cnt[i] <= 0.
  - Otherwise wait_cnt[i] <= wait_cnt[i]+1, saturating at 2^p_wait_sz-1.
  - starve[i] is a registered output equal to (wait_cnt[i] >= p_starve_limit); it is 0 from reset.
- Fire counter:
  - Increments by 1 on each edge where |amo_fire.
  - Wraps modulo 2^p_cnt_sz with no saturation.
- Protocol error, set and held until reset when any of the following occurs at an edge:
  - amo_fire is not one-hot-or-zero;
  - amo_fire[i]=1 while amo_grant[i]=0;
  - amo_fire[i]=1 while amo_req[i]=0.
- In an erroneous multi-hot fire cycle:
  - rr_ptr advances past the lowest-index firing port;
  - fire_cnt increments by 1 only.
- A request that drops before it fires is legal. That port's counter clears, and the grant moves on combinationally.
- Single port (p_num_ports=1): the pointer is constant 0, and amo_grant equals amo_req.
- Reset mid-operation: all state clears on that edge. Pending requests are re-arbitrated from port 0 in the first cycle after reset.

Decomposition:
- Shared package vc_test_mem_pkg: VC_MEM_REQ_MSG_TYPE_* AMO encodings, a max-ports constant of 16, and a function rr_next(idx, n).
- One sub-module, vc_rr_pick. It is a purely combinational round-robin one-hot picker with inputs req[N] and ptr, and output grant[N].
- The scheduler instantiates vc_rr_pick and holds all state.

Test Plan (p_num_ports=4, p_starve_limit=4):
- Reset, then amo_req=4'b1111 with each granted port firing in the same cycle -> grants 0001,0010,0100,1000,0001 on consecutive cycles; amo_fire_count=5.
- amo_req=4'b0100 with fire withheld for 3 cycles, then fired -> grant 0100 held all 4 cycles; rr_ptr then equals 3; starve stays 0.
- amo_req=4'b1010, port 1 never fires for 6 cycles -> grant stays 0010; wait_cnt[3] reaches 4 at the 4th edge; starve=4'b1000 from the following cycle.
- amo_fire=4'b0001 while amo_grant=4'b0010 -> protocol_err=1 next cycle; it stays 1 until reset.
- Requests 4'b1111 with rr_ptr=2, reset asserted for 1 cycle -> amo_grant=0 during reset; next cycle grant 0001; counters 0.
- 2^p_cnt_sz fires (p_cnt_sz overridden to 4, 16 fires) -> amo_fire_count wraps to 0.
